// File: rtl/xbar_rr_switch_if.sv
// ----------------------------------------------------------------------------
// xbar_rr_switch_if
//
// Purpose:
//   Bundles the flit-side signals of the round-robin crossbar. Each input
//   lane carries a flit, its destination output index and a valid flag. Each
//   output lane carries a registered flit with valid/ready back-pressure.
//   Drop statistics travel with the bus so one handle connects everything.
//
// Modports:
//   slave  - the switch: consumes input flits, produces output flits
//   master - the environment: produces input flits, consumes output flits
//
// Signals:
//   in_valid  [N_PORTS]          input i presents a flit
//   in_dest   [N_PORTS*DEST_W]   destination of input i at [i*DEST_W +: DEST_W]
//   in_data   [N_PORTS*DATA_W]   payload of input i at [i*DATA_W +: DATA_W]
//   in_ready  [N_PORTS]          flit on input i is consumed this cycle
//   out_valid [N_PORTS]          output register j holds a flit
//   out_data  [N_PORTS*DATA_W]   payload of output register j
//   out_ready [N_PORTS]          downstream takes output j this cycle
//   drop_cnt  [8]                saturating count of illegal-destination flits
// ----------------------------------------------------------------------------
interface xbar_rr_switch_if #(
    parameter int DATA_W  = 64,
    parameter int N_PORTS = 2,
    parameter int DEST_W  = $clog2(N_PORTS)
);
    logic [N_PORTS-1:0]        in_valid;
    logic [N_PORTS*DEST_W-1:0] in_dest;
    logic [N_PORTS*DATA_W-1:0] in_data;
    logic [N_PORTS-1:0]        in_ready;
    logic [N_PORTS-1:0]        out_valid;
    logic [N_PORTS*DATA_W-1:0] out_data;
    logic [N_PORTS-1:0]        out_ready;
    logic [7:0]                drop_cnt;

    modport slave (
        input  in_valid,
        input  in_dest,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_data,
        input  out_ready,
        output drop_cnt
    );

    modport master (
        output in_valid,
        output in_dest,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_data,
        output out_ready,
        input  drop_cnt
    );
endinterface

// File: rtl/xbar_rr_switch.sv
// ----------------------------------------------------------------------------
// xbar_rr_switch
//
// Purpose:
//   N x N registered crossbar for the butterfly NoC. Every flit carries its
//   own destination output index. Each output owns a round-robin arbiter that
//   chooses among the inputs addressing it, and a one-entry output register
//   with valid/ready back-pressure. A flit whose destination is not a real
//   output is consumed and counted in drop_cnt, which saturates at 255.
//
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-low reset; clears all state, forces in_ready=0
//   bus  - xbar_rr_switch_if.slave carrying input flits, output flits and
//          the drop counter
//
// Parameters:
//   DATA_W  - flit payload width
//   N_PORTS - number of input and output ports (2..8)
//   DEST_W  - width of each destination field
// ----------------------------------------------------------------------------
module xbar_rr_switch #(
    parameter int DATA_W  = 64,
    parameter int N_PORTS = 2,
    parameter int DEST_W  = $clog2(N_PORTS)
) (
    input  logic           clk,
    input  logic           rst,
    xbar_rr_switch_if.slave bus
);

    // Arbiter pointers, output registers and the drop counter.
    logic [N_PORTS-1:0][DEST_W-1:0] ptr_q, ptr_d;
    logic [N_PORTS-1:0]             out_valid_q, out_valid_d;
    logic [N_PORTS-1:0][DATA_W-1:0] out_data_q, out_data_d;
    logic [7:0]                     drop_cnt_q, drop_cnt_d;

    // Combinational decode and arbitration results.
    logic [N_PORTS-1:0]               dest_legal;
    logic [N_PORTS-1:0]               in_drop;
    logic [N_PORTS-1:0][N_PORTS-1:0]  req;
    logic [N_PORTS-1:0]               out_free;
    logic [N_PORTS-1:0]               grant_vld;
    logic [N_PORTS-1:0][DEST_W-1:0]   grant_idx;
    logic [N_PORTS-1:0]               in_granted;
    logic [8:0]                       drop_sum;

    // Zero-extends the destination field of input i so that the legality
    // test stays a plain 32-bit comparison for every N_PORTS.
    function automatic logic [31:0] dest_of(input logic [N_PORTS*DEST_W-1:0] v,
                                            input int i);
        return 32'(v[i*DEST_W +: DEST_W]);
    endfunction

    // Destination decode: each valid input with a legal destination raises
    // exactly one request line; an illegal destination raises none and is
    // marked for dropping instead.
    always_comb begin
        dest_legal = '0;
        in_drop    = '0;
        req        = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            dest_legal[i] = dest_of(bus.in_dest, i) < 32'(N_PORTS);
            in_drop[i]    = bus.in_valid[i] && !dest_legal[i];
            for (int j = 0; j < N_PORTS; j++) begin
                req[j][i] = bus.in_valid[i] && dest_legal[i] &&
                            (dest_of(bus.in_dest, i) == 32'(j));
            end
        end
    end

    // Per-output round-robin arbitration. An output can take a new flit when
    // its register is empty or being drained on this same edge. The scan
    // starts at the pointer and wraps, so the first hit is the fair winner.
    always_comb begin
        out_free  = '0;
        grant_vld = '0;
        grant_idx = '0;
        for (int j = 0; j < N_PORTS; j++) begin
            out_free[j] = !out_valid_q[j] || bus.out_ready[j];
            for (int off = 0; off < N_PORTS; off++) begin
                int idx;
                idx = (int'(ptr_q[j]) + off) % N_PORTS;
                if (out_free[j] && !grant_vld[j] && req[j][idx]) begin
                    grant_vld[j] = 1'b1;
                    grant_idx[j] = DEST_W'(idx);
                end
            end
        end
    end

    // Next-state for the output registers and pointers. A grant loads the
    // register even when the old flit leaves on the same edge, which is what
    // gives full throughput under a steady out_ready. The pointer moves to
    // just past the winner so the winner becomes lowest priority next time.
    always_comb begin
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        in_granted  = '0;
        for (int j = 0; j < N_PORTS; j++) begin
            if (grant_vld[j]) begin
                in_granted[grant_idx[j]] = 1'b1;
                out_valid_d[j] = 1'b1;
                out_data_d[j]  = bus.in_data[int'(grant_idx[j])*DATA_W +: DATA_W];
                if (int'(grant_idx[j]) == N_PORTS - 1) begin
                    ptr_d[j] = '0;
                end else begin
                    ptr_d[j] = grant_idx[j] + 1'b1;
                end
            end else if (bus.out_ready[j]) begin
                out_valid_d[j] = 1'b0;
            end
        end
    end

    // Drop counter: several inputs may drop in one cycle, so the sum is
    // formed one bit wider than the counter and clamped to 255.
    always_comb begin
        drop_sum = {1'b0, drop_cnt_q};
        for (int i = 0; i < N_PORTS; i++) begin
            drop_sum = drop_sum + 9'(in_drop[i]);
        end
        if (drop_sum > 9'd255) begin
            drop_cnt_d = 8'hFF;
        end else begin
            drop_cnt_d = drop_sum[7:0];
        end
    end

    // State registers. Reset is asynchronous so held flits vanish the moment
    // rst falls, without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q       <= '0;
            out_valid_q <= '0;
            out_data_q  <= '0;
            drop_cnt_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // in_ready covers both a real grant and the discard of an illegal
    // destination; it is held low throughout reset.
    assign bus.in_ready  = rst ? (in_granted | ~dest_legal) : '0;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_xbar_rr_switch.sv
// ----------------------------------------------------------------------------
// tb_xbar_rr_switch
//
// Self-checking bench for xbar_rr_switch. Three instances (2, 3 and 4 ports)
// share clock and reset. Accepted flits are pushed into per-output queues and
// popped as each output beat is delivered.
// ----------------------------------------------------------------------------
module tb_xbar_rr_switch;

    localparam int DW = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    xbar_rr_switch_if #(.DATA_W(DW), .N_PORTS(2)) bus2 ();
    xbar_rr_switch_if #(.DATA_W(DW), .N_PORTS(3)) bus3 ();
    xbar_rr_switch_if #(.DATA_W(DW), .N_PORTS(4)) bus4 ();

    xbar_rr_switch #(.DATA_W(DW), .N_PORTS(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
    xbar_rr_switch #(.DATA_W(DW), .N_PORTS(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));
    xbar_rr_switch #(.DATA_W(DW), .N_PORTS(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    // Expected output flits per output port, oldest first.
    logic [63:0] sb2 [2][$];
    logic [63:0] sb4 [4][$];

    // Counts one comparison and reports it if the values differ.
    task automatic checkOutput(input string tag, input logic [63:0] got,
                               input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Output monitors: an output must be valid exactly when a flit is queued
    // for it, must show the oldest queued payload, and delivers on out_ready.
    task automatic mon2();
        for (int j = 0; j < 2; j++) begin
            logic ev;
            ev = (sb2[j].size() != 0);
            checkOutput($sformatf("out_valid2[%0d]", j), 64'(bus2.out_valid[j]), 64'(ev));
            if (ev) begin
                checkOutput($sformatf("out_data2[%0d]", j), bus2.out_data[j*DW +: DW], sb2[j][0]);
                if (bus2.out_ready[j]) void'(sb2[j].pop_front());
            end
        end
    endtask

    task automatic mon4();
        for (int j = 0; j < 4; j++) begin
            logic ev;
            ev = (sb4[j].size() != 0);
            checkOutput($sformatf("out_valid4[%0d]", j), 64'(bus4.out_valid[j]), 64'(ev));
            if (ev) begin
                checkOutput($sformatf("out_data4[%0d]", j), bus4.out_data[j*DW +: DW], sb4[j][0]);
                if (bus4.out_ready[j]) void'(sb4[j].pop_front());
            end
        end
    endtask

    // One cycle on the 2-port switch: drive at the falling edge, check the
    // registered outputs and in_ready, then queue what should be accepted.
    task automatic applyStimulus2(input logic [1:0] v, input logic [1:0] d,
                                  input logic [63:0] d0, input logic [63:0] d1,
                                  input logic [1:0] ordy, input logic [1:0] exp_rdy);
        @(negedge clk);
        bus2.in_valid  = v;
        bus2.in_dest   = d;
        bus2.in_data   = {d1, d0};
        bus2.out_ready = ordy;
        #1;
        mon2();
        checkOutput("in_ready2", 64'(bus2.in_ready), 64'(exp_rdy));
        if (v[0] && exp_rdy[0]) sb2[d[0]].push_back(d0);
        if (v[1] && exp_rdy[1]) sb2[d[1]].push_back(d1);
    endtask

    task automatic applyStimulus4(input logic [3:0] v, input logic [7:0] d,
                                  input logic [255:0] data, input logic [3:0] ordy,
                                  input logic [3:0] exp_rdy);
        @(negedge clk);
        bus4.in_valid  = v;
        bus4.in_dest   = d;
        bus4.in_data   = data;
        bus4.out_ready = ordy;
        #1;
        mon4();
        checkOutput("in_ready4", 64'(bus4.in_ready), 64'(exp_rdy));
        for (int i = 0; i < 4; i++) begin
            if (v[i] && exp_rdy[i]) sb4[d[i*2 +: 2]].push_back(data[i*DW +: DW]);
        end
    endtask

    // Hard time bound so the bench always reaches its summary line.
    initial begin
        #200000;
        bad++;
        $display("[TB] FAIL watchdog: got=timeout expected=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int cnt [4];
        logic [255:0] fdata;

        // Reset held with traffic present on every input.
        bus2.in_valid = 2'b11; bus2.in_dest = 2'b01;
        bus2.in_data = {64'hB1, 64'hA0}; bus2.out_ready = 2'b11;
        bus3.in_valid = 3'b111; bus3.in_dest = {2'd3, 2'd1, 2'd0};
        bus3.in_data = '1; bus3.out_ready = 3'b111;
        bus4.in_valid = '0; bus4.in_dest = '0; bus4.in_data = '0; bus4.out_ready = '1;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_out_valid2", 64'(bus2.out_valid), 64'd0);
        checkOutput("rst_in_ready2", 64'(bus2.in_ready), 64'd0);
        checkOutput("rst_out_valid3", 64'(bus3.out_valid), 64'd0);
        checkOutput("rst_in_ready3", 64'(bus3.in_ready), 64'd0);
        checkOutput("rst_drop_cnt3", 64'(bus3.drop_cnt), 64'd0);

        // Release on an idle bus, then the first flit i0 -> dest 1.
        bus2.in_valid = '0;
        bus3.in_valid = '0; bus3.in_dest = '0;
        @(negedge clk);
        rst = 1'b1;
        applyStimulus2(2'b01, 2'b01, 64'h11, 64'h0, 2'b11, 2'b01);
        applyStimulus2(2'b00, 2'b00, 64'h0, 64'h0, 2'b11, 2'b00);
        applyStimulus2(2'b00, 2'b00, 64'h0, 64'h0, 2'b11, 2'b00);

        // Disjoint traffic: i0 -> 1, i1 -> 0 in the same cycle.
        applyStimulus2(2'b11, 2'b01, 64'hA0, 64'hB1, 2'b11, 2'b11);
        applyStimulus2(2'b00, 2'b00, 64'h0, 64'h0, 2'b11, 2'b00);
        applyStimulus2(2'b00, 2'b00, 64'h0, 64'h0, 2'b11, 2'b00);

        // Back-pressure: 0x44 parks on out 0 while i1 waits with 0x55.
        applyStimulus2(2'b01, 2'b00, 64'h44, 64'h0, 2'b00, 2'b01);
        repeat (5) applyStimulus2(2'b10, 2'b00, 64'h0, 64'h55, 2'b00, 2'b00);
        applyStimulus2(2'b10, 2'b00, 64'h0, 64'h55, 2'b01, 2'b10);
        applyStimulus2(2'b00, 2'b00, 64'h0, 64'h0, 2'b11, 2'b00);
        applyStimulus2(2'b00, 2'b00, 64'h0, 64'h0, 2'b11, 2'b00);

        // Fairness: four inputs hammer output 2; grants rotate 0,1,2,3,0,1.
        // A waiting input keeps its payload until it is granted.
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        for (int c = 0; c < 6; c++) begin
            int k;
            k = c % 4;
            for (int i = 0; i < 4; i++) fdata[i*DW +: DW] = 64'h1000 * (i + 1) + 64'(cnt[i]);
            applyStimulus4(4'hF, 8'b10101010, fdata, 4'hF, 4'(1 << k));
            cnt[k]++;
        end
        applyStimulus4(4'h0, 8'h00, '0, 4'hF, 4'h0);
        applyStimulus4(4'h0, 8'h00, '0, 4'hF, 4'h0);

        // Illegal destination on the 3-port switch: 300 flits to dest 3.
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            bus3.in_valid = 3'b001;
            bus3.in_dest  = {2'd0, 2'd0, 2'd3};
            bus3.in_data  = 192'(n);
            #1;
            checkOutput("drop_in_ready3", 64'(bus3.in_ready), 64'b001);
            checkOutput("drop_out_valid3", 64'(bus3.out_valid), 64'd0);
            checkOutput($sformatf("drop_cnt3@%0d", n), 64'(bus3.drop_cnt),
                        64'((n > 255) ? 255 : n));
        end
        @(negedge clk);
        bus3.in_valid = '0; bus3.in_dest = '0;
        #1;
        checkOutput("drop_cnt3_final", 64'(bus3.drop_cnt), 64'd255);
        checkOutput("drop_out_valid3_final", 64'(bus3.out_valid), 64'd0);

        // Mid-operation reset: park 0x77 (pointer of out 0 moves to 1),
        // then pull reset between edges.
        applyStimulus2(2'b01, 2'b00, 64'h77, 64'h0, 2'b00, 2'b01);
        applyStimulus2(2'b00, 2'b00, 64'h0, 64'h0, 2'b00, 2'b00);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("midrst_out_valid2", 64'(bus2.out_valid), 64'd0);
        checkOutput("midrst_in_ready2", 64'(bus2.in_ready), 64'd0);
        sb2[0].delete();
        sb2[1].delete();
        @(negedge clk);
        rst = 1'b1;
        applyStimulus2(2'b11, 2'b00, 64'hC0, 64'hC1, 2'b11, 2'b01);
        applyStimulus2(2'b10, 2'b00, 64'h0, 64'hC1, 2'b11, 2'b10);
        applyStimulus2(2'b00, 2'b00, 64'h0, 64'h0, 2'b11, 2'b00);
        applyStimulus2(2'b00, 2'b00, 64'h0, 64'h0, 2'b11, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/xbar_rr_switch.md
# xbar_rr_switch

Parametrised N×N registered crossbar switch for the butterfly NoC. It supersedes the fixed 2×2 select-driven crossbar. Each output port has its own round-robin arbiter that picks among inputs addressing it, and a one-entry output register with valid/ready back-pressure. Destination is carried with each flit rather than supplied as an external select. It sits between the butterfly stage input links and the next-stage links or local ejection ports.

## Interface
- DATA_W, 64, flit payload width in bits
- N_PORTS, 2, number of input and output ports; legal range 2..8
- DEST_W, $clog2(N_PORTS), width of each per-input destination field

- clk  input  1  system clock; all state updates on its rising edge
- rst  input  1  reset, asynchronous and active-low; state is cleared while rst=0
- in_valid  input  N_PORTS  input i presents a flit
- in_dest  input  N_PORTS*DEST_W  destination output index for input i, in slice [i*DEST_W +: DEST_W]
- in_data  input  N_PORTS*DATA_W  payload for input i, in slice [i*DATA_W +: DATA_W]
- in_ready  output  N_PORTS  flit on input i is consumed this cycle
- out_valid  output  N_PORTS  output register j holds a flit
- out_data  output  N_PORTS*DATA_W  output register j payload
- out_ready  input  N_PORTS  downstream accepts output j this cycle
- drop_cnt  output  8  saturating count of flits discarded for an illegal destination

## Operation
- **Output free condition:** output j is free when `!out_valid[j] || out_ready[j]`.
- **Requests:** req[j][i] = in_valid[i] && in_dest[i]==j && in_dest[i]<N_PORTS.
- **Arbitration:**
  - Each output j has an arbiter with pointer ptr[j] of width DEST_W.
  - When output j is free and at least one req[j][*] is set, the arbiter grants the first requesting input found scanning from ptr[j] upward, wrapping modulo N_PORTS.
  - On a grant to input k, ptr[j] <= (k+1) mod N_PORTS.
  - If no grant occurs, ptr[j] holds.
- **in_ready[i]:** asserted when input i is granted by its destination output, or when in_dest[i] >= N_PORTS (the drop case). It is combinational from in_valid, in_dest, out_valid and out_ready. It never depends on in_data.
- **Illegal destinations:** a flit with in_dest >= N_PORTS is accepted and discarded. drop_cnt increments by the number of such flits in the cycle and saturates at 255. This case is only reachable when N_PORTS is not a power of two.
- **Output register update:**
  - On a grant, out_data[j] <= the granted payload and out_valid[j] <= 1.
  - Else if out_ready[j] is high, out_valid[j] <= 0 and out_data[j] holds.
  - Otherwise out_valid[j] and out_data[j] hold.
- **Non-blocking:** inputs targeting different outputs are independent, so up to N_PORTS flits move per cycle.
- **Flit ownership:** a flit is never duplicated or lost. Each accepted legal flit appears on exactly one out_valid beat.

## Timing
- **Reset values (rst=0):**
  - out_valid=0, out_data=0, drop_cnt=0, every ptr=0.
  - in_ready is forced to 0 while rst=0.
  - Reset asserted mid-transfer discards any held flits immediately, without waiting for a clock edge.
- **Latency:** 1 cycle. A flit accepted at edge t is visible on out_valid/out_data after edge t.
- **Throughput:** 1 flit per cycle per output while out_ready is held high, because the drain and refill happen on the same edge.
- **Back-pressure:** while out_valid[j]=1 and out_ready[j]=0, out_data[j] is stable, and every in_ready[i] with in_dest[i]==j is 0.
- **Input stability rule:** an input that sees in_ready=0 must hold in_valid, in_dest and in_data. The switch does not buffer rejected flits.
- **Simultaneous events:** an output draining and being granted on the same edge loads the new flit. The old flit counts as delivered.
- **Fairness:** under continuous contention from m inputs for one free output, each input is granted once every m cycles.

## Test plan
- **Reset values:** hold rst=0 with stimulus driven on all inputs -> out_valid=0, in_ready=0, drop_cnt=0. Release rst on an idle bus -> the first flit, i0 to dest 1 with data 0x11, appears on out 1 one cycle after acceptance.
- **Disjoint traffic, N_PORTS=2:** i0→dest 1 with data 0xA0 and i1→dest 0 with data 0xB1 in the same cycle -> both in_ready=1. Next cycle out_data[1]=0xA0 and out_data[0]=0xB1, both valid.
- **Contention fairness, N_PORTS=4:** inputs 0..3 all target dest 2 continuously with out_ready[2]=1 -> grant order 0,1,2,3,0,1 on consecutive cycles, one flit per cycle.
- **Back-pressure:** out_ready[0]=0 for 5 cycles while i1 holds 0x55 for dest 0 behind held flit 0x44 -> out_data[0]=0x44 is stable and in_ready[1]=0 throughout. On the first out_ready=1 cycle, 0x55 loads on that same edge.
- **Illegal destination, N_PORTS=3:** 300 flits with dest 3 -> each gets in_ready=1 and out_valid stays 0. drop_cnt reads 255 after the 255th flit and stays at 255.
- **Mid-operation reset:** assert rst=0 asynchronously between clock edges while out_valid=1 -> out_valid falls to 0 without waiting for an edge. After release, ptr is back at 0: with inputs 1 and 0 both contending for output 0, input 0 is granted first.
